segment_display_scheduler: RTL
==============================

Name: segment_display_scheduler

Overview:
SPI-configured sequencer for the single 7-segment display.
- An SPI-slave front end receives 16-bit command frames and writes a 4-slot segment buffer plus control registers.
- A scheduler FSM then steps the display through the active slots: each slot is shown for a programmable dwell time, with an optional blank gap and blink.
- The block sits between the SPI pins on ui_in and the segment outputs on uo_out.

Parameters:
DWELL_CYCLES, 24'd10_000_000, clk cycles each slot is shown (min 2)
BLANK_CYCLES, 24'd1_000_000, clk cycles of all-off between slots; 0 = no gap

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
spi_sclk  input  1  SPI clock, async to clk; mode 0
spi_cs_n  input  1  SPI chip select, active-low, async
spi_mosi  input  1  SPI data in, MSB first, async
seg_out  output  8  segments a..g in bits 0..6, dp in bit 7; active-high; registered
slot_idx  output  2  index of slot currently scheduled; registered
frame_err  output  1  one-cycle pulse on a malformed frame
busy  output  1  high while spi_cs_n (synchronised) is low

Behaviour:
Reset (async, rst=1)
- slots[0..3]=8'h00, count=1, enable=0, blink=0.
- FSM=IDLE; seg_out=0, slot_idx=0, frame_err=0, busy=0.
- Bit counter, shift register and dwell/blank counters cleared.
- rst asserted mid-frame or mid-dwell: everything returns to reset state; the partial frame is lost.

SPI front end
- sclk, cs_n and mosi each pass through a 2-FF synchroniser.
- Rising edge of synced sclk while synced cs_n=0: shift mosi into a 16-bit register; bit counter saturates at 17.
- Falling edge of synced cs_n: clear bit counter.
- Rising edge of synced cs_n:
  - counter==16: commit the frame. Commit is 3 clk cycles after the pin edge; register effects are visible on the next cycle.
  - otherwise: frame_err=1 for exactly one cycle; nothing written.
- Frame layout: [15:12]=cmd, [11:8]=addr, [7:0]=data.
  - cmd 1: slots[addr[1:0]] <= data.
  - cmd 2: count <= data[2:0]. data[2:0]=0 is ignored; values >4 clamp to 4.
  - cmd 3: enable <= data[0], blink <= data[1].
  - any other cmd: ignored, no error.

Scheduler FSM
- States: IDLE, SHOW, BLANK.
- IDLE: seg_out=0, slot_idx=0. When enable=1, go to SHOW with idx=0 and dwell counter=0.
- SHOW: seg_out = slots[idx], reloaded every cycle, so a write to the displayed slot shows 1 cycle after commit.
  - blink=1: seg_out=0 while dwell counter >= DWELL_CYCLES/2.
  - At dwell counter == DWELL_CYCLES-1:
    - BLANK_CYCLES>0: go to BLANK.
    - BLANK_CYCLES==0: advance idx and stay in SHOW with counter=0.
- BLANK: seg_out=0. After BLANK_CYCLES cycles, advance idx and return to SHOW.
- Advance rule: idx = (idx==count-1) ? 0 : idx+1. With count=1, idx stays 0.
- Commit of cmd 2 making idx >= new count: idx=0 and dwell restarts next cycle.
- enable cleared in any state: go to IDLE next cycle; seg_out=0, idx=0.
- Simultaneous commit and dwell expiry: the register write takes effect first; the advance uses the new count.
- Counters are 24-bit and never wrap in normal operation.

Test Plan:
- Reset release → seg_out=0, slot_idx=0, frame_err=0, busy=0. Assert rst mid-frame → partial frame discarded; a following valid frame is still accepted.
- DWELL=8, BLANK=0. Write slots 0..3=8'h3F,06,5B,4F, then cmd2 data 4, then cmd3 data 1 → seg_out cycles 3F,06,5B,4F,3F, each held 8 cycles; slot_idx 0,1,2,3,0.
- BLANK=2, count=2 → pattern per slot is 8 cycles of the slot value, then 2 cycles of 0; idx 0→1→0.
- Send a 12-bit frame, then a 20-bit frame → frame_err pulses once per frame (1 cycle each); slot contents unchanged.
- While showing idx=3, send cmd2 data 2 → next cycle idx=0 with dwell restarted. Send cmd2 data 7 → count=4. Send cmd2 data 0 → no change.
- blink=1, DWELL=8 → 4 cycles of the slot value, then 4 cycles of 0. cmd3 data 0 mid-SHOW → IDLE next cycle, seg_out=0.

Source files
------------

// File: rtl/segment_display_scheduler_if.sv
// segment_display_scheduler_if: SPI pins in, segment outputs out.
// The master side drives SPI; the slave side is the scheduler.
interface segment_display_scheduler_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic [7:0] seg_out;
  logic [1:0] slot_idx;
  logic       frame_err;
  logic       busy;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  seg_out, slot_idx, frame_err, busy
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output seg_out, slot_idx, frame_err, busy
  );
endinterface

// File: rtl/segment_display_scheduler.sv
// segment_display_scheduler: SPI-written 4-slot buffer and a
// dwell/blank/blink scheduler driving one 7-segment display.
module segment_display_scheduler #(
  parameter logic [23:0] DWELL_CYCLES = 24'd10_000_000,
  parameter logic [23:0] BLANK_CYCLES = 24'd1_000_000
) (
  input logic clk,
  input logic rst,
  segment_display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [23:0] DWELL_LAST = DWELL_CYCLES - 24'd1;
  localparam logic [23:0] DWELL_HALF = DWELL_CYCLES >> 1;
  localparam logic [23:0] BLANK_LAST = BLANK_CYCLES - 24'd1;

  // [0],[1] synchroniser stages, [2] previous synced value
  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [15:0] shreg_q;
  logic [4:0]  bits_q;
  logic        err_q;

  logic        sclk_rise;
  logic        cs_rise;
  logic        cs_fall;
  logic        commit;

  logic [7:0]  slots_q [4];
  logic [7:0]  slots_d [4];
  logic [2:0]  count_q, count_d;
  logic        en_q, en_d;
  logic        blink_q, blink_d;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] dcnt_q, dcnt_d;
  logic [7:0]  seg_q, seg_d;
  logic [1:0]  idx_adv;

  // two-flop synchronisers plus one history flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign commit    = cs_rise && (bits_q == 5'd16);

  // frame shifter, saturating bit counter and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= 16'h0000;
      bits_q  <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= cs_rise && (bits_q != 5'd16);
      if (cs_fall) begin
        bits_q <= 5'd0;
      end else if (sclk_rise && !cs_q[1]) begin
        shreg_q <= {shreg_q[14:0], mosi_q[1]};
        if (bits_q != 5'd17) bits_q <= bits_q + 5'd1;
      end
    end
  end

  // decode a committed frame into the register file
  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    en_d    = en_q;
    blink_d = blink_q;
    if (commit) begin
      case (shreg_q[15:12])
        4'd1: slots_d[shreg_q[9:8]] = shreg_q[7:0];
        4'd2: begin
          if (shreg_q[2:0] > 3'd4) count_d = 3'd4;
          else if (shreg_q[2:0] != 3'd0) count_d = shreg_q[2:0];
        end
        4'd3: begin
          en_d    = shreg_q[0];
          blink_d = shreg_q[1];
        end
        default: ;
      endcase
    end
  end

  // register file state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slots_q[i] <= 8'h00;
      count_q <= 3'd1;
      en_q    <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      en_q    <= en_d;
      blink_q <= blink_d;
    end
  end

  // wrap to slot 0 after the last active slot; uses post-commit count
  assign idx_adv = ({1'b0, idx_q} == count_d - 3'd1) ? 2'd0 : idx_q + 2'd1;

  // scheduler next state; a same-cycle commit is seen before the step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    if (!en_d) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      dcnt_d  = 24'd0;
    end else if (state_q == IDLE || {1'b0, idx_q} >= count_d) begin
      state_d = SHOW;
      idx_d   = 2'd0;
      dcnt_d  = 24'd0;
    end else if (state_q == SHOW) begin
      if (dcnt_q == DWELL_LAST) begin
        dcnt_d = 24'd0;
        if (BLANK_CYCLES != 24'd0) state_d = BLANK;
        else idx_d = idx_adv;
      end else begin
        dcnt_d = dcnt_q + 24'd1;
      end
    end else begin
      if (dcnt_q == BLANK_LAST) begin
        state_d = SHOW;
        idx_d   = idx_adv;
        dcnt_d  = 24'd0;
      end else begin
        dcnt_d = dcnt_q + 24'd1;
      end
    end
    seg_d = 8'h00;
    if (state_d == SHOW && !(blink_d && dcnt_d >= DWELL_HALF))
      seg_d = slots_d[idx_d];
  end

  // scheduler state and registered segment drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      dcnt_q  <= 24'd0;
      seg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.slot_idx  = idx_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = ~cs_q[1];

endmodule
